// File: rtl/rll_keyed_pipe_if.sv
// Valid/ready data bus between the stimulus source and the key-gated pipeline.
// The master drives the upstream beat and downstream ready; the slave is the pipeline.
interface rll_keyed_pipe_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rll_keyed_pipe.sv
// Key-gated elastic pipeline: ingress XOR/XNOR key gates followed by STAGES
// valid/ready registers, with a serially loaded shadow key committed atomically.
module rll_keyed_pipe #(
  parameter int               DATA_W   = 32,
  parameter int               KEY_W    = 32,
  parameter logic [KEY_W-1:0] POLARITY = '0,
  parameter int               STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_si,
  input  logic                key_shift,
  input  logic                key_commit,
  rll_keyed_pipe_if.slave     bus,
  output logic [1:0]          key_state,
  output logic                key_err
);

  localparam int CNT_W = $clog2(KEY_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } key_fsm_t;

  key_fsm_t          state;
  logic [KEY_W-1:0]  shadow;
  logic [KEY_W-1:0]  active_key;
  logic [CNT_W-1:0]  cnt;
  logic              committed;

  logic [STAGES-1:0] v;
  logic [DATA_W-1:0] d [STAGES];
  logic [STAGES-1:0] adv;
  logic [DATA_W-1:0] gated;

  // A stage advances unless it and every stage after it are full while downstream stalls.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      full   = full & v[j];
      adv[j] = bus.out_ready | ~full;
    end
  end

  always_comb begin
    gated = bus.in_data;
    for (int i = 0; i < KEY_W; i++) begin
      gated[i] = bus.in_data[i] ^ active_key[i] ^ POLARITY[i];
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_data  = d[STAGES-1];
  assign key_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int j = 0; j < STAGES; j++) begin
        d[j] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= bus.in_valid;
        if (bus.in_valid) begin
          d[0] <= gated;
        end
      end
      for (int j = 1; j < STAGES; j++) begin
        if (adv[j]) begin
          v[j] <= v[j-1];
          if (v[j-1]) begin
            d[j] <= d[j-1];
          end
        end
      end
    end
  end

  // Rejected commits fall back to ARMED only if some key has already been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      active_key <= '0;
      cnt        <= '0;
      committed  <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      key_err <= 1'b0;
      if (key_shift && key_commit) begin
        key_err <= 1'b1;
        shadow  <= '0;
        cnt     <= '0;
        state   <= committed ? ARMED : IDLE;
      end else if (key_shift) begin
        shadow <= {shadow[KEY_W-2:0], key_si};
        if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
        state <= LOAD;
      end else if (key_commit) begin
        cnt <= '0;
        if (state == LOAD && cnt == CNT_FULL) begin
          active_key <= shadow;
          committed  <= 1'b1;
          state      <= ARMED;
        end else begin
          key_err <= 1'b1;
          if (state == LOAD) begin
            state <= committed ? ARMED : IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rll_keyed_pipe.sv
// Randomised and directed bench for rll_keyed_pipe against a queue-based
// scoreboard and a bit-list key model.
module tb_rll_keyed_pipe;
  localparam int         DATA_W = 8;
  localparam int         KEY_W  = 8;
  localparam int         STAGES = 2;
  localparam logic [7:0] POL    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_si = 1'b0;
  logic       key_shift = 1'b0;
  logic       key_commit = 1'b0;
  logic [1:0] key_state;
  logic       key_err;

  rll_keyed_pipe_if #(.DATA_W(DATA_W)) bus ();

  rll_keyed_pipe #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .POLARITY(POL), .STAGES(STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_si(key_si), .key_shift(key_shift),
    .key_commit(key_commit), .bus(bus), .key_state(key_state), .key_err(key_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         acc_cyc;
  } beat_t;

  beat_t      exp_q[$];
  bit         key_bits[$];
  bit         loading;
  bit         ever;
  logic [7:0] ref_key;
  bit         ref_err;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [7:0] bitsToKey();
    logic [7:0] k = '0;
    foreach (key_bits[i]) k = {k[6:0], key_bits[i]};
    return k;
  endfunction

  task automatic resetModel();
    exp_q.delete();
    key_bits.delete();
    loading = 1'b0;
    ever    = 1'b0;
    ref_key = '0;
    ref_err = 1'b0;
  endtask

  // One clock cycle: drive, check handshake outputs, advance the model at the edge.
  task automatic applyStimulus(input bit iv, input logic [7:0] din, input bit ordy,
                               input bit sh, input bit si, input bit cm, output bit accepted);
    bit    exp_ready, exp_valid, model_acc, deliver;
    beat_t b;
    bus.in_valid  = iv;
    bus.in_data   = din;
    bus.out_ready = ordy;
    key_shift     = sh;
    key_si        = si;
    key_commit    = cm;
    #1;
    exp_ready = (exp_q.size() < STAGES) || ordy;
    exp_valid = 1'b0;
    if (exp_q.size() > 0) exp_valid = (cyc - exp_q[0].acc_cyc) >= STAGES - 1;
    checkOutput("in_ready", bus.in_ready, exp_ready);
    checkOutput("out_valid", bus.out_valid, exp_valid);
    if (exp_valid && bus.out_valid) checkOutput("out_data", bus.out_data, exp_q[0].data);
    accepted  = iv && bus.in_ready;
    model_acc = iv && exp_ready;
    deliver   = exp_valid && ordy;
    @(posedge clk);
    cyc++;
    if (deliver) void'(exp_q.pop_front());
    if (model_acc) begin
      b.data    = din ^ ref_key ^ POL;
      b.acc_cyc = cyc;
      exp_q.push_back(b);
    end
    ref_err = 1'b0;
    if (sh && cm) begin
      ref_err = 1'b1;
      key_bits.delete();
      loading = 1'b0;
    end else if (sh) begin
      key_bits.push_back(si);
      loading = 1'b1;
    end else if (cm) begin
      if (loading && key_bits.size() == KEY_W) begin
        ref_key = bitsToKey();
        ever    = 1'b1;
      end else begin
        ref_err = 1'b1;
      end
      key_bits.delete();
      loading = 1'b0;
    end
    @(negedge clk);
    checkOutput("key_state", key_state, loading ? 2'd1 : (ever ? 2'd2 : 2'd0));
    checkOutput("key_err", key_err, ref_err);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    key_shift = 1'b0; key_si = 1'b0; key_commit = 1'b0;
    #1;
    resetModel();
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_key_state", key_state, 0);
    checkOutput("rst_key_err", key_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sendBeat(input logic [7:0] din, input bit cm);
    bit acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) applyStimulus(1, din, 1, 0, 0, (t == 0) ? cm : 1'b0, acc);
    checkOutput("accept_timeout", acc, 1);
  endtask

  task automatic shiftKey(input logic [7:0] val, input int nbits);
    bit acc;
    for (int i = nbits - 1; i >= 0; i--) applyStimulus(0, 0, 1, 1, val[i], 0, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) applyStimulus(0, 0, 1, 0, 0, 0, acc);
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int idx;
    @(negedge clk);
    doReset();

    sendBeat(8'h00, 0);
    drain();

    shiftKey(8'hA5, 8);
    applyStimulus(0, 0, 1, 0, 0, 1, acc);
    sendBeat(8'h3C, 0);
    drain();

    shiftKey(8'h55, 7);
    applyStimulus(0, 0, 1, 0, 0, 1, acc);
    sendBeat(8'h3C, 0);
    drain();

    idx = 0;
    for (int t = 0; t < 5; t++) begin
      applyStimulus(idx < 4, 8'(idx + 1), 0, 0, 0, 0, acc);
      if (acc) idx++;
    end
    checkOutput("stall_accepts", idx, 2);
    for (int t = 0; t < 30 && (idx < 4 || exp_q.size() > 0); t++) begin
      applyStimulus(idx < 4, 8'(idx + 1), 1, 0, 0, 0, acc);
      if (acc) idx++;
    end
    checkOutput("stream_sent", idx, 4);
    checkOutput("stream_empty", exp_q.size(), 0);

    doReset();
    shiftKey(8'hA5, 8);
    sendBeat(8'h00, 1);
    sendBeat(8'h00, 0);
    drain();

    doReset();
    shiftKey(8'h0F, 4);
    applyStimulus(1, 8'h11, 0, 0, 0, 0, acc);
    applyStimulus(1, 8'h22, 0, 0, 0, 0, acc);
    doReset();
    sendBeat(8'h00, 0);
    drain();

    // Random traffic with interleaved full-length loads, short loads and collisions.
    for (int n = 0; n < 40; n++) begin
      int seg = $urandom_range(0, 2);
      int len = $urandom_range(6, 10);
      for (int t = 0; t < 16; t++) begin
        bit sh = 1'b0, cm = 1'b0;
        int r = $urandom_range(0, 99);
        if (seg == 1) begin
          sh = (t < len);
          cm = (t == len);
        end else if (seg == 2) begin
          sh = (r < 20) || (r == 99);
          cm = (r >= 95);
        end
        applyStimulus($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 9) < 7,
                      sh, $urandom_range(0, 1), cm, acc);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
